// File: rtl/sign_extender_if.sv
// Operand/result bundle for the sign/zero-extension stage.
// The master side presents operands; the slave side returns widened results.
interface sign_extender_if #(
    parameter int W = 8
);
    localparam int SW = $clog2(2 * W);

    logic             in_valid;
    logic [W-1:0]     input_data;
    logic             mode;
    logic [SW-1:0]    shamt;
    logic [2*W-1:0]   extended_data;
    logic             out_valid;

    modport master (
        output in_valid,
        output input_data,
        output mode,
        output shamt,
        input  extended_data,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  input_data,
        input  mode,
        input  shamt,
        output extended_data,
        output out_valid
    );
endinterface

// File: rtl/sign_extender.sv
// Registered sign-/zero-extension from W to 2W bits with an optional left shift.
// One pipeline stage; the result register holds its value between valid inputs.
module sign_extender #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    sign_extender_if.slave  bus
);
    localparam int SW = $clog2(2 * W);

    logic [2*W-1:0] data_p1;
    logic           vld_p1;
    logic [2*W-1:0] widened_p0;

    // Signed cast lets the tool replicate the MSB; zero mode clears the upper half.
    function automatic logic [2*W-1:0] extend(input logic [W-1:0] d, input logic zext);
        logic signed [W-1:0]   s;
        logic signed [2*W-1:0] sx;
        s  = signed'(d);
        sx = (2*W)'(s);
        return zext ? {{W{1'b0}}, d} : sx;
    endfunction

    function automatic logic [2*W-1:0] shift_left(input logic [2*W-1:0] v, input logic [SW-1:0] n);
        return v << n;
    endfunction

    always_comb begin
        widened_p0 = shift_left(extend(bus.input_data, bus.mode), bus.shamt);
    end

    // Stage p0 -> p1: capture result only on valid input so idle cycles hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                data_p1 <= widened_p0;
            end
        end
    end

    assign bus.extended_data = data_p1;
    assign bus.out_valid     = vld_p1;
endmodule

// File: tb/tb_sign_extender.sv
// Bench for sign_extender: table vectors, hand-written hold/reset sequences and
// random operands, all checked through a queue of expected results.
module tb_sign_extender;
    localparam int W = 8;

    logic clk;
    logic rst;

    sign_extender_if #(.W(W)) bus ();

    sign_extender #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        m;
        logic [3:0]  s;
        logic [15:0] exp;
    } vec_t;

    vec_t         tbl[9];
    logic [15:0]  sb_q[$];
    logic [15:0]  held;
    int           n_checks;
    int           n_fail;

    // Arithmetic reference: interpret operand as an integer, scale by 2**shamt, keep 16 bits.
    function automatic logic [15:0] model(input logic [7:0] d, input logic m, input logic [3:0] s);
        int v;
        int r;
        v = int'(d);
        if (!m && d[7]) v = v - 256;
        r = v * (1 << s);
        return 16'(r);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic m,
                        input logic [3:0] s, input logic [15:0] exp);
        logic [15:0] e;
        rst            = r;
        bus.in_valid   = v;
        bus.input_data = d;
        bus.mode       = m;
        bus.shamt      = s;
        if (v && !r) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        check("out_valid", {15'b0, bus.out_valid}, {15'b0, (v && !r)});
        if (r) begin
            held = 16'h0000;
            sb_q.delete();
            check("reset_data", bus.extended_data, 16'h0000);
        end else if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got %h expected none", bus.extended_data);
            end else begin
                e = sb_q.pop_front();
                held = e;
                check("data", bus.extended_data, e);
            end
        end else begin
            check("hold_data", bus.extended_data, held);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rm;
        logic [3:0] rs;
        n_checks = 0;
        n_fail   = 0;
        held     = 16'h0000;

        tbl[0] = '{8'hFF, 1'b0, 4'd0,  16'hFFFF};
        tbl[1] = '{8'h80, 1'b0, 4'd0,  16'hFF80};
        tbl[2] = '{8'h75, 1'b0, 4'd0,  16'h0075};
        tbl[3] = '{8'hF2, 1'b0, 4'd0,  16'hFFF2};
        tbl[4] = '{8'hF2, 1'b1, 4'd0,  16'h00F2};
        tbl[5] = '{8'h80, 1'b1, 4'd0,  16'h0080};
        tbl[6] = '{8'hF2, 1'b0, 4'd4,  16'hFF20};
        tbl[7] = '{8'h75, 1'b0, 4'd15, 16'h8000};
        tbl[8] = '{8'hFF, 1'b1, 4'd8,  16'hFF00};

        // Reset with valid input present: input is dropped.
        step(1'b1, 1'b1, 8'hFF, 1'b0, 4'd0, 16'h0000);
        step(1'b1, 1'b1, 8'hFF, 1'b0, 4'd0, 16'h0000);

        // Back-to-back table vectors.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, tbl[i].d, tbl[i].m, tbl[i].s, tbl[i].exp);
        end

        // Hold: one valid, then idle cycles with toggling data.
        step(1'b0, 1'b1, 8'h80, 1'b0, 4'd0, 16'hFF80);
        step(1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 16'h0000);
        step(1'b0, 1'b0, 8'hFF, 1'b0, 4'd7, 16'h0000);
        step(1'b0, 1'b0, 8'h55, 1'b1, 4'd1, 16'h0000);

        // Reset mid-stream, then recovery.
        step(1'b0, 1'b1, 8'h42, 1'b0, 4'd0, 16'h0042);
        step(1'b1, 1'b0, 8'h42, 1'b0, 4'd0, 16'h0000);
        step(1'b0, 1'b0, 8'h33, 1'b0, 4'd0, 16'h0000);
        step(1'b0, 1'b1, 8'h01, 1'b0, 4'd0, 16'h0001);

        // Zero input across modes/shifts, and most negative operand shifted.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00, i[0], 4'(i * 5), 16'h0000);
        end
        step(1'b0, 1'b1, 8'h80, 1'b0, 4'd1, 16'hFF00);
        step(1'b0, 1'b1, 8'h80, 1'b0, 4'd8, 16'h8000);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            rs = 4'($urandom_range(0, 15));
            step(1'b0, ($urandom_range(0, 3) != 0), rd, rm, rs, model(rd, rm, rs));
        end

        step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 16'h0000);
        check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sign_extender.md
Name: sign_extender

Overview:
- Registered sign-/zero-extension unit. Widens a W-bit operand to 2W bits, with an optional logical left shift after extension.
- Sits in the datapath ahead of the ALU and multiplier, where immediates and narrow operands are widened.
- Single pipeline stage with a valid flag.

Parameters:
- W, 8, width of the input operand; output is 2*W bits; W >= 2.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, qualifies input_data, mode and shamt for this cycle.
- input_data, input, W, operand to extend (two's complement when mode=0).
- mode, input, 1, 0 = sign-extend, 1 = zero-extend.
- shamt, input, $clog2(2*W), left-shift amount applied after extension.
- extended_data, output, 2*W, registered extended (and shifted) result.
- out_valid, output, 1, high for one cycle when extended_data holds a new result.

Behaviour:
- One clock, rising edge. Reset is synchronous and active-high, sampled on clk.
- Reset (rst=1 at a clock edge):
  - extended_data <= 0, out_valid <= 0.
  - rst has priority over in_valid in the same cycle; that input is dropped.
- Extension (combinational, before the register):
  - mode=0: upper W bits = input_data[W-1] replicated; lower W bits = input_data.
  - mode=1: upper W bits = 0; lower W bits = input_data.
- Shift:
  - ext << shamt, logical; zeros fill from the LSB; bits above 2W-1 are discarded.
  - shamt=0 gives the plain extension.
  - Any shamt value representable in the port (0..2W-1) is legal.
- Latency and handshake:
  - In a cycle with in_valid=1 and rst=0, the result is registered at the next rising edge.
  - Result is visible with out_valid=1 one cycle after the inputs are presented.
  - Throughput is one result per cycle; back-to-back valid inputs give back-to-back valid outputs.
  - No backpressure.
- When in_valid=0 (rst=0):
  - out_valid <= 0.
  - extended_data holds its previous value and does not update.
  - input_data, mode and shamt are don't-care.
- Boundary cases:
  - Input MSB=1 with mode=0 fills the upper half with ones.
  - All-zero input yields 0 regardless of mode or shamt.
  - Most negative input (1 followed by zeros) extends correctly.
  - If rst is asserted mid-stream, the next edge clears the outputs; the first post-reset output follows the first valid input after rst drops.
- No X propagation from the inputs when in_valid=0: outputs are driven only from the registers.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 and input_data=8'hFF → extended_data=16'h0000 and out_valid=0 on every cycle while reset is applied.
2. Sign extension (W=8, mode=0, shamt=0), valid on consecutive cycles:
   - inputs 8'hFF, 8'h80, 8'h75, 8'hF2;
   - outputs one cycle later each: 16'hFFFF, 16'hFF80, 16'h0075, 16'hFFF2;
   - out_valid=1 on each of those four cycles.
3. Zero extension (mode=1, shamt=0): 8'hF2 → 16'h00F2; 8'h80 → 16'h0080.
4. Shift:
   - mode=0, input 8'hF2, shamt=4 → 16'hFF20;
   - mode=0, input 8'h75, shamt=15 → 16'h8000;
   - mode=1, input 8'hFF, shamt=8 → 16'hFF00.
5. Hold/valid: valid 8'h80 (mode=0), then in_valid=0 for 3 cycles with input_data toggling → extended_data stays 16'hFF80 and out_valid=0 after the single valid cycle.
6. Reset mid-stream: apply rst=1 while a valid result is present → next edge gives extended_data=0 and out_valid=0; the next valid input 8'h01 yields 16'h0001.
